// File: rtl/speech_frame_buffer.sv
// Speech frame buffer: a circular sample store of WIN_LEN+FRAME_LEN entries
// that snapshots an analysis window every FRAME_LEN new samples. Samples keep
// landing outside the snapshotted window while a consumer reads it.
module speech_frame_buffer #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 80,
  parameter int WIN_LEN   = 240
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic [DATA_W-1:0] sample_in,
  output logic              frame_valid,
  input  logic              frame_ack,
  input  logic              rd_en,
  input  logic [8:0]        rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int DEPTH = WIN_LEN + FRAME_LEN;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {
    CLEAR,
    COLLECT,
    READY
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   clr_addr_q, clr_addr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   new_cnt_q, new_cnt_d;
  logic [PTR_W-1:0]   base_q, base_d;
  logic               overrun_q, overrun_d;

  logic               mem_we;
  logic [PTR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_inc;
  logic               cnt_full;
  logic               cnt_last;
  logic [PTR_W-1:0]   rd_addr;
  logic               rd_oob;
  int                 rd_sum;

  // Oldest sample of a window ending just before ptr: ptr - WIN_LEN, i.e.
  // ptr + FRAME_LEN modulo the buffer depth.
  function automatic logic [PTR_W-1:0] snap_base(input logic [PTR_W-1:0] ptr);
    int s;
    s = int'(ptr) + FRAME_LEN;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  assign wr_ptr_inc  = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
  assign cnt_full    = (new_cnt_q == CNT_W'(FRAME_LEN));
  assign cnt_last    = (new_cnt_q == CNT_W'(FRAME_LEN - 1));
  assign frame_valid = (state_q == READY);
  assign busy        = (state_q == CLEAR);
  assign overrun     = overrun_q;

  // Next-state logic: memory clear sweep, sample collection and snapshots.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wr_ptr_d   = wr_ptr_q;
    new_cnt_d  = new_cnt_q;
    base_d     = base_q;
    overrun_d  = overrun_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_ptr_q;
    mem_wdata  = sample_in;

    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        mem_wdata = '0;
        if (clr_addr_q == PTR_W'(DEPTH - 1)) begin
          state_d    = COLLECT;
          clr_addr_d = '0;
          wr_ptr_d   = '0;
          new_cnt_d  = '0;
        end else begin
          clr_addr_d = clr_addr_q + PTR_W'(1);
        end
      end

      COLLECT: begin
        if (ce) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_inc;
          if (cnt_last) begin
            base_d    = snap_base(wr_ptr_inc);
            new_cnt_d = '0;
            state_d   = READY;
          end else begin
            new_cnt_d = new_cnt_q + CNT_W'(1);
          end
        end
      end

      READY: begin
        if (ce && !cnt_full) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_inc;
          if (cnt_last) begin
            // A frame completing while the window is still held: only an
            // ack on this same cycle lets the new window replace it.
            if (frame_ack) begin
              base_d    = snap_base(wr_ptr_inc);
              new_cnt_d = '0;
            end else begin
              new_cnt_d = CNT_W'(FRAME_LEN);
            end
          end else begin
            new_cnt_d = new_cnt_q + CNT_W'(1);
            if (frame_ack) state_d = COLLECT;
          end
        end else begin
          if (ce) overrun_d = 1'b1;
          if (frame_ack) begin
            if (cnt_full) begin
              base_d    = snap_base(wr_ptr_q);
              new_cnt_d = '0;
            end else begin
              state_d = COLLECT;
            end
          end
        end
      end

      default: state_d = CLEAR;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      wr_ptr_q   <= '0;
      new_cnt_q  <= '0;
      base_q     <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      new_cnt_q  <= new_cnt_d;
      base_q     <= base_d;
      overrun_q  <= overrun_d;
    end
  end

  // Sample memory write port.
  always_ff @(posedge clk) begin
    // NOTE: the memory has no reset; the CLEAR sweep zeroes it after reset so
    // it can map onto a RAM macro.
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Window index to physical address, wrapping once around the buffer.
  always_comb begin
    rd_sum = int'(base_q) + int'(rd_idx);
    if (rd_sum >= DEPTH) rd_sum = rd_sum - DEPTH;
    rd_addr = PTR_W'(rd_sum);
    rd_oob  = (int'(rd_idx) >= WIN_LEN);
  end

  // Registered read port; indices beyond the window return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_oob ? '0 : mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_speech_frame_buffer.sv
// Self-checking bench for speech_frame_buffer: directed sample ramps, window
// reads checked through a scoreboard queue, plus flag and reset checks.
module tb_speech_frame_buffer;

  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 80;
  localparam int WIN_LEN   = 240;

  logic              clk;
  logic              rst_n;
  logic              ce;
  logic [DATA_W-1:0] sample_in;
  logic              frame_valid;
  logic              frame_ack;
  logic              rd_en;
  logic [8:0]        rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              overrun;

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  speech_frame_buffer #(
    .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .WIN_LEN(WIN_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .sample_in(sample_in),
    .frame_valid(frame_valid), .frame_ack(frame_ack), .rd_en(rd_en),
    .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sample value for the n-th stored sample of a ramp; later samples carry the
  // top bit to exercise full-width pass-through.
  function automatic logic [DATA_W-1:0] sv(input int n);
    logic [DATA_W-1:0] v;
    v = DATA_W'(n);
    if (n > 160) v = v | 16'h8000;
    return v;
  endfunction

  // Expected window entry when the window ends at the nw-th stored sample.
  function automatic logic [DATA_W-1:0] win_exp(input int nw, input int i);
    int e;
    e = nw - (WIN_LEN - 1) + i;
    return (e < 1) ? '0 : sv(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] v, input logic ack);
    ce        = 1'b1;
    sample_in = v;
    frame_ack = ack;
    tick();
    ce        = 1'b0;
    frame_ack = 1'b0;
  endtask

  task automatic gap();
    repeat (3) tick();
  endtask

  task automatic ack_pulse();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  task automatic read_one(input int i, input logic [DATA_W-1:0] e);
    exp_t x;
    x.idx  = i;
    x.data = e;
    exp_q.push_back(x);
    rd_en  = 1'b1;
    rd_idx = 9'(i);
    tick();
    rd_en  = 1'b0;
  endtask

  task automatic read_window(input int nw);
    for (int i = 0; i < WIN_LEN; i++) read_one(i, win_exp(nw, i));
    tick();
  endtask

  // Reset, then wait for the clear sweep, optionally pulsing ce during it.
  task automatic do_reset(input logic ce_during_clear);
    int n;
    rst_n     = 1'b0;
    ce        = 1'b0;
    frame_ack = 1'b0;
    rd_en     = 1'b0;
    exp_q.delete();
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 400) begin
      ce        = ce_during_clear && (n % 4 == 0);
      sample_in = 16'h7777;
      tick();
      n++;
    end
    ce = 1'b0;
    check("clear_len", 32'(n), 32'd320);
    check("clear_overrun", 32'(overrun), 32'd0);
  endtask

  // Monitor: every presented read result is matched against the scoreboard.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 32'(rd_valid), 32'd0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check($sformatf("rd_data[%0d]", x.idx), 32'(rd_data), 32'(x.data));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nstore;
    rst_n     = 1'b0;
    ce        = 1'b0;
    sample_in = '0;
    frame_ack = 1'b0;
    rd_en     = 1'b0;
    rd_idx    = '0;
    #2;

    // First frame after reset: 160 zeros then samples 1..80.
    do_reset(1'b0);
    for (int n = 1; n <= FRAME_LEN; n++) begin
      send(sv(n), 1'b0);
      if (n == FRAME_LEN - 1) check("fv_before_80", 32'(frame_valid), 32'd0);
      if (n == FRAME_LEN)     check("fv_after_80", 32'(frame_valid), 32'd1);
      gap();
    end
    read_window(80);
    read_one(240, '0);
    read_one(511, '0);
    tick();

    // No ack: 80 more samples are kept, the 81st is dropped with overrun.
    for (int n = 81; n <= 161; n++) begin
      send(sv(n), 1'b0);
      if (n == 160) check("ovr_before_drop", 32'(overrun), 32'd0);
      if (n == 161) check("ovr_after_drop", 32'(overrun), 32'd1);
      gap();
    end
    check("fv_held", 32'(frame_valid), 32'd1);
    read_window(80);
    ack_pulse();
    check("fv_resnap", 32'(frame_valid), 32'd1);
    read_window(160);

    // Five more frames with ack before each; pointer wraps past 319.
    nstore = 160;
    for (int f = 0; f < 5; f++) begin
      ack_pulse();
      check("fv_released", 32'(frame_valid), 32'd0);
      for (int k = 0; k < FRAME_LEN; k++) begin
        nstore++;
        send(sv(nstore), 1'b0);
        gap();
      end
      check("fv_frame", 32'(frame_valid), 32'd1);
      read_window(nstore);
    end
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset with ce pulses during clear: none of them may be stored.
    do_reset(1'b1);
    for (int n = 1; n <= FRAME_LEN; n++) begin
      send(sv(n), 1'b0);
      gap();
    end
    read_window(80);

    // Ack on the same cycle as the 80th ce of the next frame.
    for (int n = 81; n < 160; n++) begin
      send(sv(n), 1'b0);
      gap();
    end
    send(sv(160), 1'b1);
    check("fv_ack_coincide", 32'(frame_valid), 32'd1);
    check("ovr_ack_coincide", 32'(overrun), 32'd0);
    gap();
    read_window(160);

    // Reset in the middle of a pending read.
    rd_en  = 1'b1;
    rd_idx = 9'd5;
    tick();
    rd_en = 1'b0;
    check("rd_valid_pending", 32'(rd_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrd_rd_valid", 32'(rd_valid), 32'd0);
    check("midrd_busy", 32'(busy), 32'd1);
    check("midrd_frame_valid", 32'(frame_valid), 32'd0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
